// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - control FSM sequencing register file, instruction memory and ALU
module cpu_sequencer #(
  parameter int DATA_W     = 4,
  parameter int IMEM_DEPTH = 16,
  parameter int RESULT_REG = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic              prog_wr_en,
  input  logic [3:0]        prog_addr,
  input  logic [9:0]        prog_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              reg_wr_en,
  output logic [1:0]        reg_wr_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic [1:0]        reg_rd_addr_a,
  output logic [1:0]        reg_rd_addr_b,
  input  logic [DATA_W-1:0] reg_rd_data_a,
  input  logic [DATA_W-1:0] reg_rd_data_b,
  output logic              imem_wr_en,
  output logic [3:0]        imem_addr,
  output logic [9:0]        imem_wr_data,
  input  logic [9:0]        imem_rd_data,
  output logic              alu_en,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out
);

  localparam int              PC_W    = $clog2(IMEM_DEPTH);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(IMEM_DEPTH - 1);
  localparam logic [1:0]      RES_IDX = 2'(RESULT_REG);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD0, S_LOAD1, S_FETCH, S_EXEC, S_WB, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [9:0]        ir_q, ir_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              byp_hit_q, byp_hit_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;

  // Host loader owns the write port only while idle; everything reads 0 under reset.
  assign imem_wr_en   = rst & (state_q == S_IDLE) & prog_wr_en;
  assign imem_addr    = !rst ? 4'd0 : (state_q == S_IDLE) ? prog_addr : 4'(pc_q);
  assign imem_wr_data = rst ? prog_data : 10'd0;
  assign busy         = (state_q != S_IDLE);
  assign result       = result_q;

  // Next-state and datapath strobes; every strobe defaults low outside its own state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    result_d      = result_q;
    byp_hit_d     = byp_hit_q;
    byp_data_d    = byp_data_q;
    done          = 1'b0;
    reg_wr_en     = 1'b0;
    reg_wr_addr   = 2'd0;
    reg_wr_data   = '0;
    reg_rd_addr_a = 2'd0;
    reg_rd_addr_b = 2'd0;
    alu_en        = 1'b0;
    alu_opcode    = 3'd0;
    alu_a         = '0;
    alu_b         = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op1_d   = in_1;
          op2_d   = in_2;
          state_d = S_LOAD0;
        end
      end
      S_LOAD0: begin
        reg_wr_en   = 1'b1;
        reg_wr_addr = 2'd0;
        reg_wr_data = op1_q;
        state_d     = S_LOAD1;
      end
      S_LOAD1: begin
        reg_wr_en   = 1'b1;
        reg_wr_addr = 2'd1;
        reg_wr_data = op2_q;
        pc_d        = '0;
        byp_hit_d   = 1'b0;
        state_d     = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = imem_rd_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        reg_rd_addr_a = ir_q[4:3];
        reg_rd_addr_b = ir_q[2:1];
        alu_en        = 1'b1;
        alu_opcode    = ir_q[9:7];
        alu_a         = reg_rd_data_a;
        alu_b         = reg_rd_data_b;
        state_d       = S_WB;
      end
      S_WB: begin
        reg_wr_en   = 1'b1;
        reg_wr_addr = ir_q[6:5];
        reg_wr_data = alu_out;
        // Remember a final write to the result register in case the register
        // file has not committed it by the time DONE samples its read port.
        byp_hit_d   = (ir_q[6:5] == RES_IDX);
        byp_data_d  = alu_out;
        if (ir_q[0] || pc_q == PC_LAST) begin
          state_d = S_DONE;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        done          = 1'b1;
        reg_rd_addr_a = RES_IDX;
        result_d      = byp_hit_q ? byp_data_q : reg_rd_data_a;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; asynchronous reset returns to an empty idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      result_q   <= '0;
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      result_q   <= result_d;
      byp_hit_q  <= byp_hit_d;
      byp_data_q <= byp_data_d;
    end
  end

endmodule
